// File: rtl/cnn_stream_pkg.sv
// Types and helpers shared by the CNN front-end pixel streaming blocks.
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } tx_state_t;

    function automatic int pixels_per_frame(input int image_width);
        return image_width * image_width;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with occupancy count; push on full and pop on empty are dropped.
// Latency: head is valid the cycle after the first push into an empty FIFO.
// Backpressure: full is a function of occupancy only, independent of a same-cycle pop.
module sync_fifo #(
    parameter int BitSize   = 32,
    parameter int FifoDepth = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [BitSize-1:0]           push_dat,
    input  logic                         pop,
    output logic [BitSize-1:0]           head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FifoDepth):0]   count
);
    localparam int AW = $clog2(FifoDepth);
    localparam int CW = AW + 1;

    logic [BitSize-1:0] mem [FifoDepth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CW'(FifoDepth));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_stream_tx.sv
// Purpose: buffer host pixels and stream one ImageWidth x ImageWidth frame into the first conv stage.
// Latency: out_valid rises one cycle after a qualifying edge; pixels spaced at least CyclesPerPixel apart.
// Backpressure: sink_ready low or empty FIFO stalls issue; wr_ready drops only when the FIFO is full.
module pixel_stream_tx
    import cnn_stream_pkg::*;
#(
    parameter int BitSize        = 32,
    parameter int ImageWidth     = 8,
    parameter int CyclesPerPixel = 2,
    parameter int FifoDepth      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [BitSize-1:0]           wr_data,
    output logic                         wr_ready,
    input  logic                         start,
    input  logic                         sink_ready,
    output logic                         out_valid,
    output logic [BitSize-1:0]           out_data,
    output logic                         busy,
    output logic                         frame_done,
    input  logic                         frame_release,
    output logic [$clog2(FifoDepth):0]   fifo_count
);
    localparam int PPF = pixels_per_frame(ImageWidth);
    localparam int PW  = $clog2(PPF) + 1;
    localparam int GW  = $clog2(CyclesPerPixel) + 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'(CyclesPerPixel - 1);
    localparam logic [PW-1:0] LAST_PIX   = PW'(PPF - 1);

    tx_state_t          state;
    logic [PW-1:0]      pixel_cnt;
    logic [GW-1:0]      gap;
    logic [BitSize-1:0] head;
    logic               full;
    logic               empty;
    logic               issue;

    sync_fifo #(
        .BitSize   (BitSize),
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_valid),
        .push_dat (wr_data),
        .pop      (issue),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    assign wr_ready = !full;
    assign busy     = (state != IDLE);
    assign issue    = (state == STREAM) && !empty && sink_ready && (gap == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pixel_cnt  <= '0;
            gap        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= issue;
            // The only cycle HOLD sees out_valid high is its first, right after the last pixel.
            frame_done <= (state == HOLD) && out_valid;

            if (issue) begin
                out_data  <= head;
                gap       <= GAP_RELOAD;
                pixel_cnt <= pixel_cnt + PW'(1);
            end else if (gap != '0) begin
                gap <= gap - GW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (issue && (pixel_cnt == LAST_PIX)) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (frame_release) begin
                        state     <= IDLE;
                        pixel_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: a frame-level reference model for a 4x4 instance plus directed checks on a depth-4 instance.
module tb_pixel_stream_tx;
    localparam int IW    = 4;
    localparam int CPP   = 2;
    localparam int DEPTH = 16;
    localparam int PPF   = IW * IW;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_data  = '0;
    logic        wr_ready;
    logic        start = 1'b0;
    logic        sink_ready = 1'b1;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        frame_done;
    logic        frame_release = 1'b0;
    logic [4:0]  fifo_count;

    logic        b_wr_valid = 1'b0;
    logic [31:0] b_wr_data  = '0;
    logic        b_wr_ready;
    logic        b_start = 1'b0;
    logic        b_sink_ready = 1'b1;
    logic        b_out_valid;
    logic [31:0] b_out_data;
    logic        b_busy;
    logic        b_frame_done;
    logic        b_frame_release = 1'b0;
    logic [2:0]  b_fifo_count;

    always #5 clk = ~clk;

    pixel_stream_tx #(.BitSize(32), .ImageWidth(IW), .CyclesPerPixel(CPP), .FifoDepth(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .start(start), .sink_ready(sink_ready), .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .frame_done(frame_done), .frame_release(frame_release), .fifo_count(fifo_count)
    );

    pixel_stream_tx #(.BitSize(32), .ImageWidth(2), .CyclesPerPixel(1), .FifoDepth(4)) dut_b (
        .clk(clk), .rst(rst), .wr_valid(b_wr_valid), .wr_data(b_wr_data), .wr_ready(b_wr_ready),
        .start(b_start), .sink_ready(b_sink_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .busy(b_busy), .frame_done(b_frame_done), .frame_release(b_frame_release), .fifo_count(b_fifo_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at cycle", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 streaming, 2 holding; queue mirrors FIFO contents.
    logic [31:0] mq[$];
    int          phase = 0;
    int          sent = 0;
    int          since = CPP;
    bit          last_flag = 0;
    bit          e_valid = 0;
    bit          e_done = 0;
    logic [31:0] e_data = '0;
    int          sz, ph0;
    bit          m_issue, m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            phase = 0; sent = 0; since = CPP; last_flag = 0;
            e_valid = 0; e_done = 0; e_data = '0;
        end else begin
            sz      = mq.size();
            ph0     = phase;
            m_issue = (ph0 == 1) && (sz > 0) && sink_ready && (since >= CPP);
            m_acc   = wr_valid && (sz < DEPTH);
            e_done    = last_flag;
            last_flag = 0;
            e_valid   = m_issue;
            if (m_issue) begin
                e_data = mq.pop_front();
                sent++;
                since = 1;
                if (sent == PPF) begin
                    phase = 2;
                    last_flag = 1;
                end
            end else if (since < CPP) begin
                since++;
            end
            if (m_acc) mq.push_back(wr_data);
            if (ph0 == 0 && start) phase = 1;
            if (ph0 == 2 && frame_release) begin
                phase = 0;
                sent = 0;
            end
        end
    end

    int cyc = 0;
    int frame_pix = 0;
    int frames = 0;
    int done_cyc = 0;
    int pix_cyc[16];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("out_data", out_data, e_data);
        chk("frame_done", 32'(frame_done), 32'(e_done));
        chk("busy", 32'(busy), 32'(phase != 0));
        chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
        if (!rst) begin
            if (out_valid) begin
                if (frame_pix < 16) pix_cyc[frame_pix] = cyc;
                frame_pix++;
            end
            if (frame_done) begin
                frames++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [31:0] v);
        int b;
        wr_valid = 1'b1;
        wr_data  = v;
        b = 0;
        while (!wr_ready && b < 300) begin
            step();
            b++;
        end
        if (!wr_ready) chk("push_timeout", 32'(wr_ready), 32'd1);
        step();
        wr_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) push(base + 32'(i));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_release();
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
    endtask

    task automatic wait_pix(input int n);
        int b = 0;
        while (frame_pix < n && b < 300) begin
            step();
            b++;
        end
        if (frame_pix < n) chk("wait_pix_timeout", 32'(frame_pix), 32'(n));
    endtask

    task automatic wait_frames(input int n);
        int b = 0;
        while (frames < n && b < 300) begin
            step();
            b++;
        end
        if (frames < n) chk("wait_frame_timeout", 32'(frames), 32'(n));
    endtask

    int start_cyc;

    initial begin
        rst = 1'b1;
        steps(3);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_fifo_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        step();

        // Full FIFO on the depth-4 instance: fifth write refused, pop while full refuses the push.
        b_wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_wr_data = 32'(50 + i);
            step();
            chk("b_fill_count", 32'(b_fifo_count), 32'((i + 1 < 4) ? i + 1 : 4));
            chk("b_fill_wr_ready", 32'(b_wr_ready), 32'(i + 1 < 4));
        end
        b_wr_valid = 1'b0;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_wr_valid = 1'b1;
        b_wr_data = 32'd99;
        step();
        b_wr_valid = 1'b0;
        chk("b_pop_full_count", 32'(b_fifo_count), 32'd3);
        chk("b_pix0", b_out_data, 32'd50);
        chk("b_pix0_valid", 32'(b_out_valid), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("b_pix_valid", 32'(b_out_valid), 32'd1);
            chk("b_pix_data", b_out_data, 32'(50 + i));
        end
        chk("b_empty_after_frame", 32'(b_fifo_count), 32'd0);
        step();
        chk("b_frame_done", 32'(b_frame_done), 32'd1);
        chk("b_no_extra_pix", 32'(b_out_valid), 32'd0);
        step();
        chk("b_frame_done_pulse", 32'(b_frame_done), 32'd0);
        chk("b_busy_hold", 32'(b_busy), 32'd1);
        b_frame_release = 1'b1;
        step();
        b_frame_release = 1'b0;
        chk("b_busy_released", 32'(b_busy), 32'd0);

        // Basic frame at two cycles per pixel.
        load(32'd0, 16);
        chk("t1_loaded_count", 32'(fifo_count), 32'd16);
        chk("t1_full_wr_ready", 32'(wr_ready), 32'd0);
        frame_pix = 0;
        start_cyc = cyc;
        pulse_start();
        wait_frames(1);
        chk("t1_first_latency", 32'(pix_cyc[0] - start_cyc), 32'd2);
        chk("t1_spacing", 32'(pix_cyc[1] - pix_cyc[0]), 32'd2);
        chk("t1_done_latency", 32'(done_cyc - start_cyc), 32'd33);
        chk("t1_pixel_total", 32'(frame_pix), 32'd16);
        steps(3);
        chk("t1_busy_hold", 32'(busy), 32'd1);
        pulse_release();
        chk("t1_busy_released", 32'(busy), 32'd0);

        // Backpressure after pixel 3.
        load(32'd100, 16);
        frame_pix = 0;
        pulse_start();
        wait_pix(4);
        sink_ready = 1'b0;
        steps(5);
        sink_ready = 1'b1;
        wait_frames(2);
        chk("t2_pixel_total", 32'(frame_pix), 32'd16);
        pulse_release();

        // Underflow: six pixels, stall, then the rest.
        load(32'd200, 6);
        frame_pix = 0;
        pulse_start();
        steps(20);
        chk("t3_stall_count", 32'(fifo_count), 32'd0);
        chk("t3_stall_pixels", 32'(frame_pix), 32'd6);
        chk("t3_no_done", 32'(frames), 32'd2);
        load(32'd206, 10);
        wait_frames(3);
        chk("t3_pixel_total", 32'(frame_pix), 32'd16);
        pulse_release();

        // Hold gating with surplus pixels left for the next frame.
        load(32'd300, 16);
        frame_pix = 0;
        pulse_start();
        load(32'd316, 4);
        wait_frames(4);
        frame_pix = 0;
        pulse_start();
        steps(3);
        pulse_start();
        steps(8);
        chk("t5_hold_count", 32'(fifo_count), 32'd4);
        chk("t5_hold_no_pix", 32'(frame_pix), 32'd0);
        chk("t5_hold_busy", 32'(busy), 32'd1);
        pulse_release();
        pulse_start();
        wait_pix(4);
        steps(6);
        chk("t5_surplus_pixels", 32'(frame_pix), 32'd4);
        chk("t5_surplus_drained", 32'(fifo_count), 32'd0);

        // Mid-frame reset after pixel 7.
        load(32'd320, 4);
        wait_pix(8);
        rst = 1'b1;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_data", out_data, 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_frame_done", 32'(frame_done), 32'd0);
        chk("t6_fifo_count", 32'(fifo_count), 32'd0);
        chk("t6_wr_ready", 32'(wr_ready), 32'd1);
        steps(2);
        rst = 1'b0;
        steps(6);
        chk("t6_no_frame_done", 32'(frames), 32'd4);
        chk("t6_no_more_pix", 32'(frame_pix), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
